// File: rtl/sfq_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfq_pipe_pkg
//  Description : Shared constants and types for the path-balanced core
//                issue/capture front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package sfq_pipe_pkg;

    // Default geometry of the 27-input / 6-output benchmark core class
    localparam int SFQ_IN_W       = 27;
    localparam int SFQ_OUT_W      = 6;
    localparam int SFQ_DEPTH      = 9;
    localparam int SFQ_FIFO_DEPTH = 16;
    localparam int SFQ_TAG_W      = 8;

    // Issue/drain controller states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // One queued result: sequence tag above core output data
    typedef struct packed {
        logic [SFQ_TAG_W-1:0] tag;
        logic [SFQ_OUT_W-1:0] data;
    } result_t;

endpackage : sfq_pipe_pkg
`default_nettype wire

// File: rtl/sfq_pipe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sfq_pipe_fifo
//  Description : Synchronous result FIFO with occupancy count and a head
//                entry read straight from the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfq_pipe_fifo #(
    parameter int WIDTH     = 14,
    parameter int N_ENTRIES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_valid,
    output logic [$clog2(N_ENTRIES):0]     o_count
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [N_ENTRIES];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(N_ENTRIES));
    assign w_do_pop  = i_pop & ~w_empty;
    // A push into a full queue is only legal when the head leaves the same edge
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_count = r_count;

endmodule : sfq_pipe_fifo
`default_nettype wire

// File: rtl/sfq_pipe_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sfq_pipe_driver
//  Description : Issues one vector per cycle into a fixed-depth balanced core,
//                tracks in-flight slots, captures tagged results into a queue
//                and throttles issue with credits so no result is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfq_pipe_driver
    import sfq_pipe_pkg::*;
#(
    parameter int IN_W       = SFQ_IN_W,
    parameter int OUT_W      = SFQ_OUT_W,
    parameter int DEPTH      = SFQ_DEPTH,
    parameter int FIFO_DEPTH = SFQ_FIFO_DEPTH,
    parameter int TAG_W      = SFQ_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic [IN_W-1:0]    core_x,
    input  logic [OUT_W-1:0]   core_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               flush,
    output logic               flush_done
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PEND_W = $clog2(DEPTH + FIFO_DEPTH + 1);
    localparam int RES_W  = TAG_W + OUT_W;

    logic [IN_W-1:0]   r_core_x;
    logic [DEPTH-1:0]  r_inflight;
    logic [TAG_W-1:0]  r_tag_cnt;
    logic [TAG_W-1:0]  r_tag_pipe [DEPTH];
    state_e            r_state;

    state_e            w_state_nxt;
    logic              w_ready;
    logic              w_flush_done;
    logic              w_accept;
    logic              w_capture;
    logic              w_fifo_valid;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [RES_W-1:0]  w_fifo_rdata;
    logic [PEND_W-1:0] w_inflight_cnt;
    logic [PEND_W-1:0] w_pending;

    assign w_accept  = in_valid & w_ready;
    assign w_capture = r_inflight[DEPTH-1];

    // Issue register, in-flight marker shift and tag shift; idle cycles drive zeros into the core
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_core_x   <= '0;
            r_inflight <= '0;
            r_tag_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag_pipe[i] <= '0;
            end
        end else begin
            r_core_x      <= w_accept ? in_data : '0;
            r_inflight[0] <= w_accept;
            r_tag_pipe[0] <= r_tag_cnt;
            for (int i = 1; i < DEPTH; i++) begin
                r_inflight[i] <= r_inflight[i-1];
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
            if (w_accept) begin
                r_tag_cnt <= r_tag_cnt + TAG_W'(1);
            end
        end
    end

    // Credits: every issued vector reserves a queue slot until it is popped
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_inflight_cnt = w_inflight_cnt + PEND_W'(r_inflight[i]);
        end
        w_pending = w_inflight_cnt + PEND_W'(w_fifo_count);
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, issue permission and drain completion; ready is held low while reset is applied
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready = rst_n & (w_pending < PEND_W'(FIFO_DEPTH));
                if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_inflight == '0) && !w_fifo_valid) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    sfq_pipe_fifo #(
        .WIDTH     (RES_W),
        .N_ENTRIES (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_capture),
        .i_wdata ({r_tag_pipe[DEPTH-1], core_y}),
        .i_pop   (out_ready),
        .o_rdata (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign in_ready   = w_ready;
    assign core_x     = r_core_x;
    assign out_valid  = w_fifo_valid;
    assign out_tag    = w_fifo_rdata[RES_W-1:OUT_W];
    assign out_data   = w_fifo_rdata[OUT_W-1:0];
    assign flush_done = w_flush_done;

endmodule : sfq_pipe_driver
`default_nettype wire
